// File: rtl/mem_block_copier_pkg.sv
// Shared definitions for the block copier: FSM state encoding and copy direction.
package mem_block_copier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } copy_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } copy_dir_e;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Source/destination address pair: loaded at copy start, stepped +/-1 per word, wraps.
module mem_copy_addr_gen
  import mem_block_copier_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  load,
  input  logic                  step,
  input  copy_dir_e             dir,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] src,
  output logic [ADDR_WIDTH-1:0] dst
);

  copy_dir_e             dir_q;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] delta;

  // Descending copies start at the last word so overlapping regions copy safely.
  assign offset = (dir == DIR_DOWN) ? length - ADDR_WIDTH'(1) : '0;
  assign delta  = (dir_q == DIR_DOWN) ? '1 : ADDR_WIDTH'(1);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      src   <= '0;
      dst   <= '0;
      dir_q <= DIR_UP;
    end else if (load) begin
      src   <= src_base + offset;
      dst   <= dst_base + offset;
      dir_q <= dir;
    end else if (step) begin
      src <= src + delta;
      dst <= dst + delta;
    end
  end

endmodule

// File: rtl/mem_block_copier.sv
// Word-by-word memory block copier: one read then one write per word, memmove-safe.
module mem_block_copier
  import mem_block_copier_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iSrcAddr,
  input  logic [ADDR_WIDTH-1:0] iDstAddr,
  input  logic [ADDR_WIDTH-1:0] iLength,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [DATA_WIDTH-1:0] oMemData,
  input  logic [DATA_WIDTH-1:0] iMemData
);

  copy_state_e           state, nstate;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic                  start;
  copy_dir_e             dir;

  assign start = (state == ST_IDLE) && iStart;
  assign dir   = (iDstAddr > iSrcAddr) ? DIR_DOWN : DIR_UP;

  mem_copy_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (start),
    .step     (state == ST_WRITE),
    .dir      (dir),
    .src_base (iSrcAddr),
    .dst_base (iDstAddr),
    .length   (iLength),
    .src      (src),
    .dst      (dst)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= nstate;
      if (start)
        count <= iLength;
      else if (state == ST_WRITE)
        count <= count - ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  if (iStart) nstate = (iLength != '0) ? ST_READ : ST_DONE;
      ST_READ:  nstate = ST_WRITE;
      ST_WRITE: nstate = (count == ADDR_WIDTH'(1)) ? ST_DONE : ST_READ;
      ST_DONE:  nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
  end

  // Memory side decodes registered state only; iStart never reaches these outputs.
  always_comb begin
    oBusy        = 1'b0;
    oDone        = 1'b0;
    oWriteEnable = 1'b0;
    oAddress     = '0;
    oMemData     = '0;
    case (state)
      ST_READ: begin
        oBusy    = 1'b1;
        oAddress = src;
      end
      ST_WRITE: begin
        oBusy        = 1'b1;
        oWriteEnable = 1'b1;
        oAddress     = dst;
        oMemData     = iMemData;
      end
      ST_DONE: oDone = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Scoreboard bench for mem_block_copier with a registered-read RAM model.
module tb_mem_block_copier;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iStart;
  logic [9:0] iSrcAddr, iDstAddr, iLength;
  logic       oBusy, oDone, oWriteEnable;
  logic [9:0] oAddress;
  logic [7:0] oMemData, iMemData;

  always #5 Clock = ~Clock;

  mem_block_copier #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStart       (iStart),
    .iSrcAddr     (iSrcAddr),
    .iDstAddr     (iDstAddr),
    .iLength      (iLength),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oWriteEnable (oWriteEnable),
    .oAddress     (oAddress),
    .oMemData     (oMemData),
    .iMemData     (iMemData)
  );

  // RAM with bench-side preload port
  logic [7:0] ram [0:1023];
  logic       clr, pl_en;
  logic [9:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge Clock) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
    end else if (pl_en) ram[pl_addr] <= pl_data;
    else if (oWriteEnable) ram[oAddress] <= oMemData;
    iMemData <= ram[oAddress];
  end

  typedef struct packed { logic [9:0] a; logic [7:0] d; } wr_t;
  wr_t        wr_q[$];
  logic [9:0] rd_q[$];
  logic [7:0] ref_mem [0:1023];
  int         n_checks = 0, n_errors = 0;
  int         wr_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every read address and write strobe is matched in order.
  always @(negedge Clock) begin
    if (oWriteEnable) begin
      wr_count++;
      if (wr_q.size() == 0) chk("wr_extra", 1, 0);
      else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", oAddress, e.a);
        chk("wr_data", oMemData, e.d);
      end
    end else if (oBusy) begin
      if (rd_q.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd_addr", oAddress, rd_q.pop_front());
    end
  end

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    @(negedge Clock);
    pl_en = 1'b0;
  endtask

  // memmove reference: expected traffic for the first n word pairs
  task automatic push_expect(input logic [9:0] src, input logic [9:0] dst,
                             input logic [9:0] len, input int n);
    logic [7:0] old [0:1023];
    logic [9:0] k, sa, da;
    bit desc;
    old  = ref_mem;
    desc = dst > src;
    for (int i = 0; i < n; i++) begin
      k  = desc ? 10'(int'(len) - 1 - i) : 10'(i);
      sa = src + k;
      da = dst + k;
      rd_q.push_back(sa);
      wr_q.push_back({da, old[sa]});
      ref_mem[da] = old[sa];
    end
  endtask

  task automatic run_copy(input logic [9:0] src, input logic [9:0] dst,
                          input logic [9:0] len, input bit junk);
    int busy_cyc, done_cyc;
    push_expect(src, dst, len, int'(len));
    wr_count = 0; busy_cyc = 0; done_cyc = -1;
    iStart = 1'b1; iSrcAddr = src; iDstAddr = dst; iLength = len;
    @(posedge Clock);
    for (int c = 1; c <= 2 * int'(len) + 4; c++) begin
      @(negedge Clock);
      if (oBusy) busy_cyc++;
      if (oDone) begin
        if (done_cyc < 0) done_cyc = c;
        else chk("done_twice", 1, 0);
      end
      if (junk && done_cyc < 0) begin
        iStart = 1'b1; iSrcAddr = 10'($urandom); iDstAddr = 10'($urandom); iLength = 10'($urandom);
      end else iStart = 1'b0;
    end
    chk("done_cycle", done_cyc, 2 * int'(len) + 1);
    chk("busy_cycles", busy_cyc, 2 * int'(len));
    chk("write_count", wr_count, int'(len));
    chk("wr_q_left", wr_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    for (int i = 0; i < int'(len); i++)
      chk("mem_ref", ram[10'(dst + 10'(i))], ref_mem[10'(dst + 10'(i))]);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDone, 0);
    chk({tag, "_we"},   oWriteEnable, 0);
    chk({tag, "_addr"}, oAddress, 0);
    chk({tag, "_data"}, oMemData, 0);
  endtask

  initial begin
    Reset = 1'b1; iStart = 1'b0; iSrcAddr = '0; iDstAddr = '0; iLength = '0;
    clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    repeat (2) @(negedge Clock);
    clr = 1'b0;
    check_idle_outputs("reset");
    Reset = 1'b0;
    @(negedge Clock);

    // basic ascending copy
    for (int i = 0; i < 4; i++) preload(10'(i), 8'h10 + 8'(i));
    run_copy(10'd0, 10'd100, 10'd4, 1'b0);
    for (int i = 0; i < 4; i++) chk("basic_mem", ram[100 + i], 8'h10 + 8'(i));

    // overlapping copy goes descending; iStart during busy ignored
    for (int i = 0; i < 5; i++) preload(10'(i), 8'hA0 + 8'(i));
    run_copy(10'd0, 10'd2, 10'd5, 1'b1);
    for (int i = 0; i < 5; i++) chk("overlap_mem", ram[2 + i], 8'hA0 + 8'(i));

    // zero length
    run_copy(10'd7, 10'd9, 10'd0, 1'b0);

    // source wraps past the top of memory
    preload(10'd1022, 8'hC0); preload(10'd1023, 8'hC1);
    preload(10'd0, 8'hC2);    preload(10'd1, 8'hC3);
    run_copy(10'd1022, 10'd10, 10'd4, 1'b0);
    for (int i = 0; i < 4; i++) chk("wrap_mem", ram[10 + i], 8'hC0 + 8'(i));

    // in-place copy still does every pair
    for (int i = 0; i < 3; i++) preload(10'(50 + i), 8'h55 + 8'(i));
    run_copy(10'd50, 10'd50, 10'd3, 1'b0);
    for (int i = 0; i < 3; i++) chk("same_mem", ram[50 + i], 8'h55 + 8'(i));

    // abort: reset lands at the end of cycle 4 of an 8-word copy
    for (int i = 0; i < 8; i++) preload(10'(200 + i), 8'h30 + 8'(i));
    for (int i = 0; i < 8; i++) preload(10'(300 + i), 8'hE0 + 8'(i));
    push_expect(10'd200, 10'd300, 10'd8, 2);
    wr_count = 0;
    iStart = 1'b1; iSrcAddr = 10'd200; iDstAddr = 10'd300; iLength = 10'd8;
    @(posedge Clock);
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      chk("abort_busy", oBusy, 1);
      chk("abort_nodone", oDone, 0);
      iStart = 1'b1; iSrcAddr = 10'($urandom); iDstAddr = 10'($urandom); iLength = 10'd5;
    end
    Reset = 1'b1;
    @(negedge Clock);
    check_idle_outputs("abort_idle");
    // reset wins over a simultaneous start in IDLE
    @(negedge Clock);
    check_idle_outputs("rst_vs_start");
    Reset = 1'b0; iStart = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (oDone || oBusy) chk("abort_quiet", {oDone, oBusy}, 0);
    end
    chk("abort_writes", wr_count, 2);
    chk("abort_wr_q", wr_q.size(), 0);
    chk("abort_rd_q", rd_q.size(), 0);
    for (int i = 0; i < 8; i++) chk("abort_mem", ram[300 + i], ref_mem[300 + i]);
    chk("abort_w307", ram[307], 8'h37);
    chk("abort_keep305", ram[305], 8'hE5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
